// File: rtl/color_dest_fetch_pkg.sv
// Shared color-buffer definitions: where each RGBA channel sits inside a packed pixel
// and how wide a pixel is.
package color_dest_fetch_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int COLOR_R_POS  = 3;
  localparam int COLOR_G_POS  = 2;
  localparam int COLOR_B_POS  = 1;
  localparam int COLOR_A_POS  = 0;

  function automatic int pixel_width(input int sub_pixel_width);
    return NUM_CHANNELS * sub_pixel_width;
  endfunction

  // Packs four 8-bit channels into one pixel using the channel positions above.
  function automatic logic [31:0] pack_rgba8(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b, input logic [7:0] a);
    logic [31:0] p;
    p = '0;
    p[COLOR_R_POS*8 +: 8] = r;
    p[COLOR_G_POS*8 +: 8] = g;
    p[COLOR_B_POS*8 +: 8] = b;
    p[COLOR_A_POS*8 +: 8] = a;
    return p;
  endfunction

endpackage

// File: rtl/color_dest_fetch_addr_hazard_tracker.sv
// Shift register of recently accepted pixel addresses with a parallel compare against
// the incoming address; flags a read-after-write hazard while a match is in flight.
module color_dest_fetch_addr_hazard_tracker
  import color_dest_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hazard_o,
  output logic                  any_valid_o
);

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DEPTH-2:0]      match;

  assign valid_d = {valid_q[DEPTH-2:0], load_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) addr_q[i] <= addr_q[i-1];
    end
  end

  // The last slot retires this cycle, so it never blocks a same-cycle re-accept.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH - 1; gi++) begin : g_cmp
      assign match[gi] = valid_q[gi] && (addr_q[gi] == addr_i);
    end
  endgenerate

  assign hazard_o    = enable_i && (|match);
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/color_dest_fetch.sv
// Fetches the destination pixel for each accepted fragment and presents source and
// destination colors aligned to the blender, stalling fragments that hit an in-flight pixel.
module color_dest_fetch
  import color_dest_fetch_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int READ_LATENCY    = 1,
  parameter int BLEND_LATENCY   = 3,
  parameter int HAZARD_DEPTH    = READ_LATENCY + BLEND_LATENCY + 2,
  localparam int PIXEL_WIDTH    = pixel_width(SUB_PIXEL_WIDTH)
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   confEnable,
  input  logic                   s_frag_valid,
  output logic                   s_frag_ready,
  input  logic [ADDR_WIDTH-1:0]  s_frag_addr,
  input  logic [PIXEL_WIDTH-1:0] s_frag_color,
  output logic                   fb_rd_en,
  output logic [ADDR_WIDTH-1:0]  fb_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] fb_rd_data,
  output logic                   m_valid,
  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic [PIXEL_WIDTH-1:0] m_sourceColor,
  output logic [PIXEL_WIDTH-1:0] m_destColor,
  output logic                   idle
);

  localparam int DL = 1 + READ_LATENCY;

  logic                   rst_sync_q;
  logic                   hazard;
  logic                   tracker_busy;
  logic                   accept;
  logic                   load_tracker;
  logic                   rd_en_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_d;

  logic [DL-1:0]          dl_valid_q;
  logic [DL-1:0]          dl_valid_d;
  logic [ADDR_WIDTH-1:0]  dl_addr_q  [DL];
  logic [ADDR_WIDTH-1:0]  dl_addr_d  [DL];
  logic [PIXEL_WIDTH-1:0] dl_color_q [DL];
  logic [PIXEL_WIDTH-1:0] dl_color_d [DL];

  // Keeps ready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 1'b0;
    else         rst_sync_q <= 1'b1;
  end

  assign s_frag_ready = rst_sync_q && !hazard;
  assign accept       = s_frag_valid && s_frag_ready;
  assign load_tracker = accept && confEnable;

  color_dest_fetch_addr_hazard_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (HAZARD_DEPTH)
  ) u_tracker (
    .clk         (aclk),
    .rst_n       (resetn),
    .enable_i    (confEnable),
    .load_i      (load_tracker),
    .addr_i      (s_frag_addr),
    .hazard_o    (hazard),
    .any_valid_o (tracker_busy)
  );

  assign rd_addr_d = load_tracker ? s_frag_addr : rd_addr_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_en_q   <= load_tracker;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign fb_rd_en   = rd_en_q;
  assign fb_rd_addr = rd_addr_q;

  // Delay line matching the read latency so source color meets read data.
  assign dl_valid_d[0] = accept;
  assign dl_addr_d[0]  = s_frag_addr;
  assign dl_color_d[0] = s_frag_color;

  genvar gi;
  generate
    for (gi = 1; gi < DL; gi++) begin : g_dl_next
      assign dl_valid_d[gi] = dl_valid_q[gi-1];
      assign dl_addr_d[gi]  = dl_addr_q[gi-1];
      assign dl_color_d[gi] = dl_color_q[gi-1];
    end
    for (gi = 0; gi < DL; gi++) begin : g_dl_reg
      always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
          dl_valid_q[gi] <= 1'b0;
          dl_addr_q[gi]  <= '0;
          dl_color_q[gi] <= '0;
        end else begin
          dl_valid_q[gi] <= dl_valid_d[gi];
          dl_addr_q[gi]  <= dl_addr_d[gi];
          dl_color_q[gi] <= dl_color_d[gi];
        end
      end
    end
  endgenerate

  assign m_valid       = dl_valid_q[DL-1];
  assign m_addr        = dl_addr_q[DL-1];
  assign m_sourceColor = dl_color_q[DL-1];
  assign m_destColor   = (confEnable && m_valid) ? fb_rd_data : '0;
  assign idle          = !tracker_busy && !(|dl_valid_q);

endmodule
